gbox_dly_seq: RTL and testbench

GBOX_DLY_SEQ -- requirements
Module: gbox_dly_seq

---
 rtl/gbox_pkg.sv | 18 +
 rtl/gbox_settle_tmr.sv | 38 +++
 rtl/gbox_dly_seq.sv | 166 ++++++++++++++++
 tb/tb_gbox_dly_seq.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/gbox_pkg.sv
// Shared types and default constants for the gbox delay-tap sequencer.
// State encoding and default timing/retry settings live here.
package gbox_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        STEP,
        SETTLE,
        CHECK,
        DONE,
        ERR
    } gbox_state_e;

    localparam int GBOX_SETTLE_DEF = 8;
    localparam int GBOX_RETRY_DEF  = 3;

endpackage

// File: rtl/gbox_settle_tmr.sv
// Settle timer: loads N on start, expire is high in the Nth cycle
// after the load, abort clears it.
module gbox_settle_tmr #(
    parameter int N = 8
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic start_i,
    input  logic abort_i,
    output logic expire_o
);

    localparam int CW = $clog2(N + 1);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (abort_i) begin
            cnt_d = '0;
        end else if (start_i) begin
            cnt_d = CW'(N);
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expire_o = (cnt_q == CW'(1));

endmodule

// File: rtl/gbox_dly_seq.sv
// Delay-tap sequencer: reloads or single-steps a delay adjuster to a target.
// Define GBOX_DLY_SEQ_RETRY_EN to compile in the readback check and retry counter.
module gbox_dly_seq
    import gbox_pkg::*;
#(
    parameter int PAR_TWID   = 6,
    parameter int PAR_SETTLE = GBOX_SETTLE_DEF,
    parameter int PAR_RETRY  = GBOX_RETRY_DEF
) (
    input  logic                core_clk,
    input  logic                system_reset_n,
    input  logic                pll_lock,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_load,
    input  logic [PAR_TWID-1:0] req_tap,
    input  logic [PAR_TWID-1:0] dly_tap,
    output logic                dly_ld,
    output logic                dly_adj,
    output logic                dly_inc,
    output logic                busy,
    output logic                done,
    output logic                err
);

    gbox_state_e         state_q, state_d;
    logic [PAR_TWID-1:0] tgt_q, tgt_d;
    logic                load_q, load_d;
    logic                err_q, err_d;
    logic                tmr_start, tmr_exp, go_up;

`ifdef GBOX_DLY_SEQ_RETRY_EN
    localparam int RW = $clog2(PAR_RETRY + 1);
    logic [RW-1:0]       retry_q, retry_d, retry_inc;
    logic [PAR_TWID-1:0] exp_q, exp_d;
`else
    localparam logic [PAR_TWID:0] STEP_MAX = {1'b1, {PAR_TWID{1'b0}}};
    logic [PAR_TWID:0]   step_q, step_d;
`endif

    assign go_up = (tgt_q > dly_tap);

    // The target compare happens in CHECK, one cycle after it is latched.
    always_comb begin
        state_d = state_q;
        tgt_d   = tgt_q;
        load_d  = load_q;
        err_d   = err_q;
`ifdef GBOX_DLY_SEQ_RETRY_EN
        retry_d   = retry_q;
        exp_d     = exp_q;
        retry_inc = retry_q + 1'b1;
`else
        step_d  = step_q;
`endif
        if (!pll_lock) begin
            state_d = IDLE;
            if (state_q != IDLE) err_d = 1'b1;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (req_valid) begin
                        err_d  = 1'b0;
                        load_d = req_load;
`ifdef GBOX_DLY_SEQ_RETRY_EN
                        retry_d = '0;
                        exp_d   = dly_tap;
`else
                        step_d  = '0;
`endif
                        if (req_load) begin
                            state_d = LOAD;
                        end else begin
                            tgt_d   = req_tap;
                            state_d = CHECK;
                        end
                    end
                end
                LOAD: state_d = SETTLE;
                STEP: begin
                    state_d = SETTLE;
`ifdef GBOX_DLY_SEQ_RETRY_EN
                    exp_d = go_up ? dly_tap + 1'b1 : dly_tap - 1'b1;
`else
                    step_d = step_q + 1'b1;
`endif
                end
                SETTLE: if (tmr_exp) state_d = CHECK;
                CHECK: begin
                    if (load_q) begin
                        state_d = DONE;
                    end else begin
`ifdef GBOX_DLY_SEQ_RETRY_EN
                        if (dly_tap == exp_q) begin
                            retry_d = '0;
                            state_d = (dly_tap == tgt_q) ? DONE : STEP;
                        end else begin
                            retry_d = retry_inc;
                            state_d = (retry_inc == RW'(PAR_RETRY)) ? ERR : SETTLE;
                        end
`else
                        if (dly_tap == tgt_q) begin
                            state_d = DONE;
                        end else if (step_q == STEP_MAX) begin
                            state_d = ERR;
                        end else begin
                            state_d = STEP;
                        end
`endif
                    end
                end
                DONE:    state_d = IDLE;
                ERR:     state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
        if (state_d == ERR) err_d = 1'b1;
    end

    always_ff @(posedge core_clk or negedge system_reset_n) begin
        if (!system_reset_n) begin
            state_q <= IDLE;
            tgt_q   <= '0;
            load_q  <= 1'b0;
            err_q   <= 1'b0;
`ifdef GBOX_DLY_SEQ_RETRY_EN
            retry_q <= '0;
            exp_q   <= '0;
`else
            step_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            tgt_q   <= tgt_d;
            load_q  <= load_d;
            err_q   <= err_d;
`ifdef GBOX_DLY_SEQ_RETRY_EN
            retry_q <= retry_d;
            exp_q   <= exp_d;
`else
            step_q  <= step_d;
`endif
        end
    end

    assign tmr_start = (state_d == SETTLE) && (state_q != SETTLE);

    gbox_settle_tmr #(
        .N(PAR_SETTLE)
    ) u_tmr (
        .clk_i   (core_clk),
        .rst_ni  (system_reset_n),
        .start_i (tmr_start),
        .abort_i (!pll_lock),
        .expire_o(tmr_exp)
    );

    assign req_ready = (state_q == IDLE) && pll_lock;
    assign dly_ld    = (state_q == LOAD) && pll_lock;
    assign dly_adj   = (state_q == STEP) && pll_lock;
    assign dly_inc   = dly_adj && go_up;
    assign busy      = (state_q != IDLE);
    assign done      = ((state_q == DONE) || (state_q == ERR)) && pll_lock;
    assign err       = err_q;

endmodule

// File: tb/tb_gbox_dly_seq.sv
// Scoreboard bench for gbox_dly_seq with a behavioural delay adjuster.
// Build with or without GBOX_DLY_SEQ_RETRY_EN.
module tb_gbox_dly_seq;

    localparam int TW = 6;
    localparam int ST = 8;
    localparam int RT = 3;
    localparam logic [TW-1:0] LD_VAL = 6'd32;

    typedef struct {
        logic err;
        int   adj;
        int   ld;
        int   lat;
    } exp_t;

    logic          core_clk = 1'b0;
    logic          system_reset_n = 1'b0;
    logic          pll_lock = 1'b0;
    logic          req_valid = 1'b0;
    logic          req_load = 1'b0;
    logic [TW-1:0] req_tap = '0;
    logic [TW-1:0] dly_tap;
    logic          req_ready, dly_ld, dly_adj, dly_inc, busy, done, err;

    exp_t          sb[$];
    exp_t          mon_e;
    int            n_chk = 0;
    int            n_err = 0;
    logic          frozen = 1'b0;
    logic          pre_en = 1'b0;
    logic [TW-1:0] pre_val = '0;
    logic [TW-1:0] cur_tgt = '0;
    int            cyc = 0;
    int            acc_cyc = 0;
    int            last_cmd = -1000;
    int            n_adj = 0;
    int            n_ld = 0;

    always #5 core_clk = ~core_clk;

    gbox_dly_seq #(
        .PAR_TWID  (TW),
        .PAR_SETTLE(ST),
        .PAR_RETRY (RT)
    ) dut (
        .core_clk      (core_clk),
        .system_reset_n(system_reset_n),
        .pll_lock      (pll_lock),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_load      (req_load),
        .req_tap       (req_tap),
        .dly_tap       (dly_tap),
        .dly_ld        (dly_ld),
        .dly_adj       (dly_adj),
        .dly_inc       (dly_inc),
        .busy          (busy),
        .done          (done),
        .err           (err)
    );

    // Delay adjuster model: reload to LD_VAL, single-step, or stay frozen.
    always @(posedge core_clk) begin
        if (pre_en) dly_tap <= pre_val;
        else if (dly_ld) dly_tap <= LD_VAL;
        else if (dly_adj && !frozen) dly_tap <= dly_inc ? dly_tap + 1'b1 : dly_tap - 1'b1;
    end

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    always @(negedge core_clk) begin
        cyc++;
        if (!system_reset_n) begin
            sb.delete();
            last_cmd = -1000;
        end else begin
            if (req_valid && req_ready) begin
                acc_cyc = cyc;
                n_adj   = 0;
                n_ld    = 0;
            end
            if (dly_adj || dly_ld) begin
                chk("cmd_excl", int'(dly_adj && dly_ld), 0);
                chk("cmd_gap", int'((cyc - last_cmd) >= ST + 1), 1);
                last_cmd = cyc;
                if (dly_adj) begin
                    n_adj++;
                    chk("adj_dir", int'(dly_inc), int'(cur_tgt > dly_tap));
                end
                if (dly_ld) n_ld++;
            end
            if (done) begin
                if (sb.size() == 0) begin
                    chk("spurious_done", 1, 0);
                end else begin
                    mon_e = sb.pop_front();
                    chk("done_err", int'(err), int'(mon_e.err));
                    chk("n_adj", n_adj, mon_e.adj);
                    chk("n_ld", n_ld, mon_e.ld);
                    if (mon_e.lat >= 0) chk("latency", cyc - acc_cyc, mon_e.lat);
                end
            end
        end
    end

    task automatic push(input logic e, input int a, input int l, input int lat);
        exp_t x;
        x.err = e;
        x.adj = a;
        x.ld  = l;
        x.lat = lat;
        sb.push_back(x);
    endtask

    task automatic preset(input logic [TW-1:0] v);
        @(posedge core_clk); #1;
        pre_en  = 1'b1;
        pre_val = v;
        @(posedge core_clk); #1;
        pre_en  = 1'b0;
    endtask

    task automatic send(input logic ld, input logic [TW-1:0] tap);
        int i;
        req_valid = 1'b1;
        req_load  = ld;
        req_tap   = tap;
        if (!ld) cur_tgt = tap;
        i = 0;
        while (!req_ready && i < 2000) begin
            @(posedge core_clk); #1;
            i++;
        end
        if (!req_ready) chk("ready_timeout", 0, 1);
        @(posedge core_clk); #1;
        req_valid = 1'b0;
    endtask

    task automatic wait_idle(input int lim);
        for (int i = 0; i < lim; i++) begin
            @(posedge core_clk); #1;
            if (sb.size() == 0 && !busy) break;
        end
        chk("idle_timeout", sb.size(), 0);
    endtask

    // Walk latency: one compare cycle, then (step + settle + check) per step, then DONE.
    function automatic int walk_lat(input int n);
        return 2 + n * (ST + 2);
    endfunction

    initial begin
        #12;
        chk("rst_outs", int'({dly_ld, dly_adj, dly_inc, busy, done, err}), 0);
        chk("rst_ready", int'(req_ready), 0);
        @(posedge core_clk); #1;
        system_reset_n = 1'b1;
        pll_lock = 1'b1;
        #1;
        chk("ready_idle", int'(req_ready), 1);

        preset(6'd10);
        push(1'b0, 3, 0, walk_lat(3));
        send(1'b0, 6'd13);
        wait_idle(200);
        chk("tap_13", int'(dly_tap), 13);
        chk("err_13", int'(err), 0);

        preset(6'd20);
        push(1'b0, 0, 0, 2);
        send(1'b0, 6'd20);
        wait_idle(50);

        push(1'b0, 0, 1, ST + 3);
        send(1'b1, 6'd0);
        wait_idle(100);
        chk("tap_load", int'(dly_tap), int'(LD_VAL));

        push(1'b0, 2, 0, walk_lat(2));
        send(1'b0, 6'd30);
        wait_idle(200);
        chk("tap_30", int'(dly_tap), 30);

        push(1'b0, 1, 0, walk_lat(1));
        push(1'b0, 1, 0, walk_lat(1));
        send(1'b0, 6'd31);
        chk("ready_busy", int'(req_ready), 0);
        send(1'b0, 6'd32);
        wait_idle(200);
        chk("tap_32", int'(dly_tap), 32);

        preset(6'd5);
        frozen = 1'b1;
`ifdef GBOX_DLY_SEQ_RETRY_EN
        push(1'b1, 1, 0, -1);
`else
        push(1'b1, 1 << TW, 0, -1);
`endif
        send(1'b0, 6'd7);
        wait_idle(2000);
        chk("frz_busy", int'(busy), 0);
        chk("frz_err", int'(err), 1);
        chk("frz_tap", int'(dly_tap), 5);
        frozen = 1'b0;

        preset(6'd10);
        send(1'b0, 6'd12);
        chk("err_clr", int'(err), 0);
        for (int i = 0; i < 50 && !dly_adj; i++) begin
            @(posedge core_clk); #1;
        end
        chk("adj_seen", int'(dly_adj), 1);
        repeat (4) @(posedge core_clk);
        #1;
        pll_lock = 1'b0;
        @(posedge core_clk); #1;
        chk("abort_busy", int'(busy), 0);
        chk("abort_err", int'(err), 1);
        chk("abort_ready", int'(req_ready), 0);
        repeat (5) @(posedge core_clk);
        #1;
        chk("lockwait_ready", int'(req_ready), 0);
        pll_lock = 1'b1;
        #1;
        chk("relock_ready", int'(req_ready), 1);

        preset(6'd10);
        send(1'b0, 6'd14);
        for (int i = 0; i < 50 && !dly_adj; i++) begin
            @(posedge core_clk); #1;
        end
        chk("adj_seen2", int'(dly_adj), 1);
        #2;
        system_reset_n = 1'b0;
        #1;
        chk("midrst_outs", int'({dly_ld, dly_adj, dly_inc, busy, done, err}), 0);
        @(posedge core_clk); #1;
        system_reset_n = 1'b1;
        chk("midrst_tap", int'(dly_tap), 10);
        push(1'b0, 2, 0, walk_lat(2));
        send(1'b0, 6'd12);
        wait_idle(200);
        chk("tap_after_rst", int'(dly_tap), 12);
        chk("err_after_rst", int'(err), 0);

        repeat (3) @(posedge core_clk);
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
